// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Machine-mode interrupt entry sequencer for a single-hart core. External
//   interrupt lines are edge-captured into per-source pending bits. Their
//   enabled OR forms MEIP. MEI/MSI/MTI are arbitrated by fixed priority into
//   a single registered trap request carrying its mcause value. Once the core
//   acknowledges a request, no further request is raised until mret.
//
// Ports
//   clock, reset          clock; asynchronous active-high reset
//   ext_irq, ext_enable   raw external levels (already synchronous) and per-source enable
//   msip, mtip            software / timer pending levels
//   mstatus_mie           global machine interrupt enable
//   mie_meie/msie/mtie    per-class enables
//   stall                 core stall; blocks raising a new request
//   trap_ack              core entered the trap this cycle
//   mret                  core executed mret this cycle
//   claim                 software claims claim_id this cycle
//   claim_id              lowest-index pending and enabled source (0 when none)
//   pending               pending register
//   meip                  OR of pending & ext_enable
//   trap_request          registered request to the core
//   trap_cause            mcause for the request; holds its value while request is low
module interrupt_controller #(
  parameter int NUM_SOURCES = 4,
  parameter int ID_WIDTH    = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] ext_irq,
  input  logic [NUM_SOURCES-1:0] ext_enable,
  input  logic                   msip,
  input  logic                   mtip,
  input  logic                   mstatus_mie,
  input  logic                   mie_meie,
  input  logic                   mie_msie,
  input  logic                   mie_mtie,
  input  logic                   stall,
  input  logic                   trap_ack,
  input  logic                   mret,
  input  logic                   claim,
  output logic [ID_WIDTH-1:0]    claim_id,
  output logic [NUM_SOURCES-1:0] pending,
  output logic                   meip,
  output logic                   trap_request,
  output logic [31:0]            trap_cause
);

  localparam logic [31:0] CAUSE_MEI = 32'h8000000B;
  localparam logic [31:0] CAUSE_MSI = 32'h80000003;
  localparam logic [31:0] CAUSE_MTI = 32'h80000007;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    HANDLING = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] ext_prev_q, ext_prev_d;
  logic                   trap_request_q, trap_request_d;
  logic [31:0]            trap_cause_q, trap_cause_d;

  logic [NUM_SOURCES-1:0] active;
  logic                   mei, msi, mti, any_irq;
  logic [31:0]            cause_sel;

  // Source selection: the loop runs from the top index down, so the lowest
  // pending and enabled index is the one written last.
  always_comb begin
    active   = pending_q & ext_enable;
    meip     = |active;
    claim_id = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (active[i]) claim_id = ID_WIDTH'(i);
    end
  end

  // Pending update. The claim clear is applied first and the new edges are
  // OR-ed in afterwards, so a set wins over a claim of the same bit.
  always_comb begin
    ext_prev_d = ext_irq;
    pending_d  = pending_q;
    if (claim && meip) begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (ID_WIDTH'(i) == claim_id) pending_d[i] = 1'b0;
      end
    end
    pending_d = pending_d | (ext_irq & ~ext_prev_q);
  end

  // Effective interrupts and fixed-priority cause (MEI > MSI > MTI).
  always_comb begin
    mei     = meip & mie_meie;
    msi     = msip & mie_msie;
    mti     = mtip & mie_mtie;
    any_irq = mstatus_mie & (mei | msi | mti);
    if (mei)      cause_sel = CAUSE_MEI;
    else if (msi) cause_sel = CAUSE_MSI;
    else          cause_sel = CAUSE_MTI;
  end

  // Request sequencing. The cause is only loaded on the IDLE->REQUEST step,
  // so it stays frozen while the request is up and holds after it drops.
  always_comb begin
    state_d        = state_q;
    trap_request_d = trap_request_q;
    trap_cause_d   = trap_cause_q;
    case (state_q)
      IDLE: begin
        if (any_irq && !stall) begin
          state_d        = REQUEST;
          trap_request_d = 1'b1;
          trap_cause_d   = cause_sel;
        end
      end
      REQUEST: begin
        if (trap_ack) begin
          state_d        = HANDLING;
          trap_request_d = 1'b0;
        end else if (!any_irq) begin
          state_d        = IDLE;
          trap_request_d = 1'b0;
        end
      end
      HANDLING: begin
        if (mret) state_d = IDLE;
      end
      default: begin
        state_d        = IDLE;
        trap_request_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      ext_prev_q     <= '0;
      trap_request_q <= 1'b0;
      trap_cause_q   <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      ext_prev_q     <= ext_prev_d;
      trap_request_q <= trap_request_d;
      trap_cause_q   <= trap_cause_d;
    end
  end

  assign pending      = pending_q;
  assign trap_request = trap_request_q;
  assign trap_cause   = trap_cause_q;

endmodule
